// File: rtl/count_ctrl_pkg.sv
// Shared encodings for the two-digit BCD counter controller: FSM states,
// anode select patterns and the terminal-count helper.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-BCD digits (above 9) never match, so they can never halt the counter.
  function automatic logic is_terminal(input logic [3:0] ones,
                                       input logic [3:0] tens,
                                       input logic       up);
    if (up) begin
      return (ones == BCD_MAX) && (tens == BCD_MAX);
    end
    return (ones == 4'd0) && (tens == 4'd0);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter with enable and synchronous load-to-zero; tick marks the
// enabled cycle in which the count wraps from N-1 back to 0.
module tick_gen #(
  parameter int  N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load0,
  output logic [W-1:0] count,
  output logic         tick
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load0) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = en && !load0 && (count_q == LAST);

endmodule

// File: rtl/count_ctrl.sv
// Run-state sequencer for the two-digit BCD counter: prescaled step enable,
// clear pulse, terminal-count halt and a two-digit multiplexed display drive.
import count_ctrl_pkg::*;

module count_ctrl #(
  parameter int DIV  = 50_000_000,
  parameter int SCAN = 100_000
) (
  input  logic       count_ctrl_clk,
  input  logic       count_ctrl_rst,
  input  logic       count_ctrl_start,
  input  logic       count_ctrl_stop,
  input  logic       count_ctrl_clear,
  input  logic       count_ctrl_dir,
  input  logic       count_ctrl_limit_en,
  input  logic [3:0] count_ctrl_ones,
  input  logic [3:0] count_ctrl_tens,
  output logic       count_ctrl_step,
  output logic       count_ctrl_up,
  output logic       count_ctrl_clr,
  output logic       count_ctrl_done,
  output logic [1:0] count_ctrl_state,
  output logic [1:0] count_ctrl_an,
  output logic [3:0] count_ctrl_digit
);

  localparam int DIV_W  = $clog2(DIV);
  localparam int SCAN_W = $clog2(SCAN);

  state_t state_q, state_d;
  logic   step_q, step_d;
  logic   up_q, up_d;
  logic   clr_q, clr_d;
  logic   done_q, done_d;
  logic [1:0] an_q, an_d;
  logic [3:0] digit_q, digit_d;

  logic presc_en;
  logic presc_load0;
  logic presc_tick;
  logic scan_tick;
  logic at_term;
  logic [DIV_W-1:0]  presc_cnt_unused;
  logic [SCAN_W-1:0] scan_cnt_unused;

  // The prescaler freezes in the cycle a stop/clear is taken, so a pause
  // keeps the value that was current when the request arrived.
  assign presc_en    = (state_q == RUN) && !count_ctrl_stop && !count_ctrl_clear;
  assign presc_load0 = (state_q == IDLE) && count_ctrl_start && !count_ctrl_clear;
  assign at_term     = is_terminal(count_ctrl_ones, count_ctrl_tens, count_ctrl_dir);

  tick_gen #(.N(DIV)) u_presc (
    .clk   (count_ctrl_clk),
    .rst   (count_ctrl_rst),
    .en    (presc_en),
    .load0 (presc_load0),
    .count (presc_cnt_unused),
    .tick  (presc_tick)
  );

  tick_gen #(.N(SCAN)) u_scan (
    .clk   (count_ctrl_clk),
    .rst   (count_ctrl_rst),
    .en    (1'b1),
    .load0 (1'b0),
    .count (scan_cnt_unused),
    .tick  (scan_tick)
  );

  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    up_d    = up_q;
    if (count_ctrl_clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (count_ctrl_start) state_d = RUN;
        RUN: begin
          if (count_ctrl_stop) begin
            state_d = PAUSE;
          end else if (presc_tick) begin
            if (count_ctrl_limit_en && at_term) begin
              state_d = DONE;
            end else begin
              step_d = 1'b1;
              up_d   = count_ctrl_dir;
            end
          end
        end
        PAUSE: if (count_ctrl_start) state_d = RUN;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign clr_d  = count_ctrl_clear;
  assign done_d = (state_d == DONE);

  // digit follows the next anode value so the pair always changes together.
  assign an_d    = scan_tick ? ~an_q : an_q;
  assign digit_d = (an_d == AN_ONES) ? count_ctrl_ones : count_ctrl_tens;

  always_ff @(posedge count_ctrl_clk) begin
    if (!count_ctrl_rst) begin
      state_q <= IDLE;
      step_q  <= 1'b0;
      up_q    <= 1'b1;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      an_q    <= AN_ONES;
      digit_q <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      up_q    <= up_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign count_ctrl_step  = step_q;
  assign count_ctrl_up    = up_q;
  assign count_ctrl_clr   = clr_q;
  assign count_ctrl_done  = done_q;
  assign count_ctrl_state = state_q;
  assign count_ctrl_an    = an_q;
  assign count_ctrl_digit = digit_q;

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Sequencing controller for the two-digit BCD up/down counter datapath (two chained `uch` digits).
- Turns start/stop/clear/direction requests into a run-state FSM.
- Generates a prescaled single-cycle step enable with direction and a clear pulse for the datapath.
- Detects terminal count (99 up, 00 down) from the fed-back digits and optionally halts there.
- Time-multiplexes the two digits onto one seven-segment decoder input with active-low anode selects.

## Interface
- `DIV`, default 50_000_000: clock cycles per step; must be ≥ 2; prescaler width is $clog2(DIV).
- `SCAN`, default 100_000: clock cycles per display digit; must be ≥ 2.
- `count_ctrl_clk`  in  1  single system clock; all state changes on its rising edge.
- `count_ctrl_rst`  in  1  synchronous, active-low reset.
- `count_ctrl_start`  in  1  single-cycle request to run or resume.
- `count_ctrl_stop`  in  1  single-cycle request to pause.
- `count_ctrl_clear`  in  1  single-cycle request to zero the datapath and return to idle.
- `count_ctrl_dir`  in  1  level; 1 = count up, 0 = count down.
- `count_ctrl_limit_en`  in  1  level; 1 = halt at terminal count instead of wrapping.
- `count_ctrl_ones`  in  4  ones digit fed back from the datapath (BCD 0–9).
- `count_ctrl_tens`  in  4  tens digit fed back from the datapath (BCD 0–9).
- `count_ctrl_step`  out  1  one-cycle step enable to the datapath.
- `count_ctrl_up`  out  1  direction qualifying `step`.
- `count_ctrl_clr`  out  1  one-cycle datapath clear.
- `count_ctrl_done`  out  1  high while halted at terminal count.
- `count_ctrl_state`  out  2  FSM state code.
- `count_ctrl_an`  out  2  active-low digit select; bit0 = ones, bit1 = tens.
- `count_ctrl_digit`  out  4  BCD value for the currently selected digit.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Request priority when asserted together: clear > stop > start.
- IDLE:
  - start → RUN, prescaler loaded with 0.
  - clear → `clr` pulse; stays in IDLE.
  - stop is ignored.
- RUN:
  - Prescaler increments every cycle and wraps DIV-1 → 0.
  - On the cycle the prescaler equals DIV-1 (the tick cycle), the controller evaluates terminal count, then either issues a step or enters DONE.
  - Terminal count is ones=9, tens=9 with dir=1, or ones=0, tens=0 with dir=0.
  - Tick with limit_en=0, or with limit_en=1 and not at terminal: `step` is 1 in the next cycle, and `up` equals `dir` sampled at the tick.
  - Tick with limit_en=1 at terminal: no step; go to DONE.
  - stop → PAUSE; the prescaler value is retained.
  - clear → IDLE with a `clr` pulse.
- PAUSE:
  - start → RUN; the prescaler resumes from its retained value, not from 0.
  - clear → IDLE with a `clr` pulse.
- DONE:
  - `done`=1.
  - start and stop are ignored.
  - clear → IDLE with a `clr` pulse; `done` falls with the state change.
- `step` and `clr` are never high in the same cycle. A clear in the tick cycle suppresses that step.
- Display scan:
  - A free-running scan counter, independent of the FSM, toggles `an` between 2'b10 and 2'b01 every SCAN cycles.
  - `digit` is registered as ones when `an`=2'b10 and tens when `an`=2'b01, so it always matches `an`.
- Input digits above 9 are never treated as terminal and pass to `digit` unchanged.

## Timing
- Reset values, applied on the first rising edge with rst=0:
  - state=IDLE
  - step=0, clr=0, done=0, up=1
  - prescaler=0, scan counter=0
  - an=2'b10, digit=0
- A reset asserted mid-run takes priority over every request and emits no `clr`.
- Every output is registered.
- start in cycle N (from IDLE):
  - state=RUN visible at N+1.
  - First `step` visible at N+DIV+1.
  - Later steps every DIV cycles.
- stop or clear in cycle N: the state change is visible at N+1; `clr` is high during N+1 only.
- Terminal halt: DONE and `done`=1 visible the cycle after the tick cycle, i.e. the same slot where `step` would have appeared.
- An `an` transition and its matching `digit` update are visible in the same cycle, every SCAN cycles.

## Structure
- Package `count_ctrl_pkg` holds:
  - the state encoding constants IDLE/RUN/PAUSE/DONE;
  - anode constants AN_ONES=2'b10 and AN_TENS=2'b01;
  - BCD_MAX=4'd9.
- One sub-module, `tick_gen` (parameter N; inputs clk, synchronous active-low rst, en, load0; outputs count and tick), is instantiated twice:
  - as the prescaler, with en = (state==RUN) and load0 on IDLE→RUN;
  - as the scan divider, with en tied to 1.
- The FSM, terminal detection and the display mux live in `count_ctrl`.

## Test plan
All scenarios use DIV=4 and SCAN=8.
- Reset, then start at cycle 10 → state=1 at cycle 11; `step`=1 at cycles 15, 19 and 23, each with `up`=1.
- Start, then stop at cycle 13, then start again at cycle 20 → state=2 during cycles 14–20 with no step; next `step` at cycle 23, because the prescaler resumes from its retained value of 2.
- limit_en=1, dir=1, digits held at 9/9, start → no `step` ever; state=3 and `done`=1 from cycle N+5.
- limit_en=0, dir=0, digits 0/0 → steps continue with `up`=0 (wrap is left to the datapath); start, stop and clear asserted together in a RUN cycle → `clr` one cycle, state=0.
- Free-running scan with ones=3, tens=7 → `an`/`digit` alternate 10/3 and 01/7, switching every 8 cycles.
- rst=0 asserted mid-RUN while `step` is pending → all outputs return to their reset values on the next edge; no `step` and no `clr`.
